// File: rtl/key_lcd_writer.sv
// key_lcd_writer: buffers hex key events in a small FIFO, converts them to
// ASCII and drives a req/ack command/data interface of an LCD character
// controller. Tracks a COLS x ROWS cursor with line wrap, DDRAM addressing,
// and optional clear/backspace edit keys.
module key_lcd_writer #(
  parameter int unsigned  COLS       = 16,
  parameter int unsigned  ROWS       = 2,
  parameter int unsigned  FIFO_DEPTH = 4,
  parameter bit           EDIT_EN    = 1'b1,
  parameter logic [3:0]   CLEAR_KEY  = 4'hF,
  parameter logic [3:0]   BS_KEY     = 4'hE,
  localparam int unsigned CW         = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned RW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [3:0]    key_value,
  output logic          lcd_req,
  output logic          lcd_rs,
  output logic [7:0]    lcd_data,
  input  logic          lcd_ack,
  output logic [CW-1:0] cur_col,
  output logic [RW-1:0] cur_row,
  output logic          busy,
  output logic          key_drop
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SET_ADDR,
    S_WRITE_CHAR,
    S_CLEAR_CMD,
    S_BS_ADDR,
    S_BS_SPACE,
    S_ADVANCE
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic          pop, push;
  logic [3:0]    head;
  logic          req_q, req_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    char_q, char_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          dirty_q, dirty_d;
  logic          drop_q, drop_d;

  // Set-DDRAM-address command for a cursor position.
  function automatic logic [7:0] addr_cmd(input logic [RW-1:0] row,
                                          input logic [CW-1:0] col);
    logic [6:0] base;
    case (2'(row))
      2'd0:    base = 7'h00;
      2'd1:    base = 7'h40;
      2'd2:    base = 7'h14;
      default: base = 7'h54;
    endcase
    return {1'b1, base + 7'(col)};
  endfunction

  // Hex key to ASCII '0'-'9', 'A'-'F'.
  function automatic logic [7:0] to_ascii(input logic [3:0] k);
    return (k < 4'd10) ? (8'h30 + {4'h0, k}) : (8'h37 + {4'h0, k});
  endfunction

  // FIFO push/pop decisions, pointer and occupancy next-state.
  always_comb begin
    pop      = (state_q == S_IDLE) && (count_q != '0);
    push     = key_valid && ((count_q < NW'(FIFO_DEPTH)) || pop);
    head     = fifo_mem[rd_ptr_q];
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + NW'(1);
    end else if (pop && !push) begin
      count_d = count_q - NW'(1);
    end
    drop_d   = key_valid && !push;
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= key_value;
    end
  end

  // FIFO pointers, occupancy and overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Next-state, handshake and cursor logic.
  // Print and clear are decoded straight from the FIFO head in IDLE so the
  // request rises two cycles after the key; DECODE is only taken by backspace,
  // which must step the cursor before its set-address can be formed.
  // Each request state raises lcd_req when entered with it low, and leaves on
  // ack with lcd_req dropped, which guarantees the idle cycle between requests.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rs_d    = rs_q;
    data_d  = data_q;
    char_d  = char_q;
    col_d   = col_q;
    row_d   = row_q;
    dirty_d = dirty_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (EDIT_EN && (head == CLEAR_KEY)) begin
            state_d = S_CLEAR_CMD;
            req_d   = 1'b1;
            rs_d    = 1'b0;
            data_d  = 8'h01;
          end else if (EDIT_EN && (head == BS_KEY)) begin
            state_d = S_DECODE;
          end else begin
            char_d = to_ascii(head);
            req_d  = 1'b1;
            if (dirty_q) begin
              state_d = S_SET_ADDR;
              rs_d    = 1'b0;
              data_d  = addr_cmd(row_q, col_q);
            end else begin
              state_d = S_WRITE_CHAR;
              rs_d    = 1'b1;
              data_d  = to_ascii(head);
            end
          end
        end
      end
      S_DECODE: begin
        if ((col_q == '0) && (row_q == '0)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BS_ADDR;
          if (col_q != '0) begin
            col_d = col_q - CW'(1);
          end else begin
            row_d = row_q - RW'(1);
            col_d = CW'(COLS - 1);
          end
        end
      end
      S_SET_ADDR: begin
        if (!req_q) begin
          req_d  = 1'b1;
          rs_d   = 1'b0;
          data_d = addr_cmd(row_q, col_q);
        end else if (lcd_ack) begin
          req_d   = 1'b0;
          dirty_d = 1'b0;
          state_d = S_WRITE_CHAR;
        end
      end
      S_WRITE_CHAR: begin
        if (!req_q) begin
          req_d  = 1'b1;
          rs_d   = 1'b1;
          data_d = char_q;
        end else if (lcd_ack) begin
          req_d   = 1'b0;
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        state_d = S_IDLE;
        if (col_q == CW'(COLS - 1)) begin
          col_d   = '0;
          dirty_d = 1'b1;
          row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_CLEAR_CMD: begin
        if (!req_q) begin
          req_d  = 1'b1;
          rs_d   = 1'b0;
          data_d = 8'h01;
        end else if (lcd_ack) begin
          req_d   = 1'b0;
          col_d   = '0;
          row_d   = '0;
          dirty_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_BS_ADDR: begin
        if (!req_q) begin
          req_d  = 1'b1;
          rs_d   = 1'b0;
          data_d = addr_cmd(row_q, col_q);
        end else if (lcd_ack) begin
          req_d   = 1'b0;
          state_d = S_BS_SPACE;
        end
      end
      S_BS_SPACE: begin
        if (!req_q) begin
          req_d  = 1'b1;
          rs_d   = 1'b1;
          data_d = 8'h20;
        end else if (lcd_ack) begin
          req_d   = 1'b0;
          dirty_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM state, handshake outputs and cursor registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      char_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      dirty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      char_q  <= char_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dirty_q <= dirty_d;
    end
  end

  assign lcd_req  = req_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;
  assign cur_col  = col_q;
  assign cur_row  = row_q;
  assign key_drop = drop_q;
  assign busy     = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_key_lcd_writer.sv
// Testbench for key_lcd_writer: LCD responder with random ack latency,
// a cursor/transaction reference model over a linear cell index, and
// one task per scenario.
module tb_key_lcd_writer;

  localparam int COLS = 16;
  localparam int ROWS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_value;
  logic       lcd_req, lcd_rs, lcd_ack;
  logic [7:0] lcd_data;
  logic [3:0] cur_col;
  logic [0:0] cur_row;
  logic       busy, key_drop;

  always #5 clk = ~clk;

  key_lcd_writer #(
    .COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(4),
    .EDIT_EN(1'b1), .CLEAR_KEY(4'hF), .BS_KEY(4'hE)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_value(key_value),
    .lcd_req(lcd_req), .lcd_rs(lcd_rs), .lcd_data(lcd_data), .lcd_ack(lcd_ack),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy), .key_drop(key_drop)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  int         m_pos;
  bit         m_dirty;
  bit         ack_hold = 1'b0;
  int         ack_max = 0;
  int         drop_cnt = 0;

  // LCD controller stand-in: acks after a random delay, logs {rs,data},
  // and checks rs/data were held since the request rose.
  initial begin : responder
    int         wait_cnt;
    int         cur_delay;
    logic       prev_req;
    logic [8:0] held;
    lcd_ack   = 1'b0;
    prev_req  = 1'b0;
    wait_cnt  = 0;
    cur_delay = 0;
    held      = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        lcd_ack  = 1'b0;
        prev_req = 1'b0;
        wait_cnt = 0;
      end else begin
        if (key_drop) drop_cnt++;
        if (lcd_req && !prev_req) begin
          held      = {lcd_rs, lcd_data};
          cur_delay = $urandom_range(0, ack_max);
          wait_cnt  = 0;
        end
        if (lcd_ack) begin
          lcd_ack = 1'b0;
        end else if (lcd_req && !ack_hold) begin
          if (wait_cnt >= cur_delay) begin
            checks++;
            if ({lcd_rs, lcd_data} !== held) begin
              errors++;
              $display("FAIL hold_stable: got %h, required %h", {lcd_rs, lcd_data}, held);
            end
            obs_q.push_back({lcd_rs, lcd_data});
            lcd_ack = 1'b1;
          end else begin
            wait_cnt++;
          end
        end
        prev_req = lcd_req;
      end
    end
  end

  // Reference model: cursor as a linear cell index; emits expected {rs,data}.
  function automatic logic [7:0] m_addr(input int pos);
    int base[4] = '{'h00, 'h40, 'h14, 'h54};
    return 8'h80 | 8'(base[pos / COLS] + (pos % COLS));
  endfunction

  task automatic model_key(input logic [3:0] k);
    int kv = int'(k);
    if (kv == 15) begin
      exp_q.push_back({1'b0, 8'h01});
      m_pos   = 0;
      m_dirty = 1'b1;
    end else if (kv == 14) begin
      if (m_pos != 0) begin
        m_pos--;
        exp_q.push_back({1'b0, m_addr(m_pos)});
        exp_q.push_back({1'b1, 8'h20});
        m_dirty = 1'b1;
      end
    end else begin
      if (m_dirty) begin
        exp_q.push_back({1'b0, m_addr(m_pos)});
        m_dirty = 1'b0;
      end
      exp_q.push_back({1'b1, (kv < 10) ? 8'(48 + kv) : 8'(65 + kv - 10)});
      m_pos = (m_pos + 1) % (COLS * ROWS);
      if (m_pos % COLS == 0) m_dirty = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    key_valid = 1'b0;
    key_value = '0;
    ack_hold  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    m_pos    = 0;
    m_dirty  = 1'b1;
    drop_cnt = 0;
  endtask

  task automatic send_key(input logic [3:0] k, input bit do_model);
    @(negedge clk);
    key_valid = 1'b1;
    key_value = k;
    if (do_model) model_key(k);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < 3000) begin
      @(negedge clk);
      n++;
      if (!busy && !lcd_req && !lcd_ack) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 4) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b req=%0b after %0d cycles, required idle", name, busy, lcd_req, n);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    key_valid = 1'b0;
    key_value = '0;
    repeat (3) @(negedge clk);
    checks++; if (lcd_req !== 1'b0)   begin errors++; $display("FAIL rst_req: got %b, required 0", lcd_req); end
    checks++; if (lcd_rs !== 1'b0)    begin errors++; $display("FAIL rst_rs: got %b, required 0", lcd_rs); end
    checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h, required 00", lcd_data); end
    checks++; if (cur_col !== 4'd0)   begin errors++; $display("FAIL rst_col: got %0d, required 0", cur_col); end
    checks++; if (cur_row !== 1'd0)   begin errors++; $display("FAIL rst_row: got %0d, required 0", cur_row); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (key_drop !== 1'b0)  begin errors++; $display("FAIL rst_drop: got %b, required 0", key_drop); end
    rst = 1'b0;
    m_pos   = 0;
    m_dirty = 1'b1;
  endtask

  task automatic test_single_key();
    ack_max = 0;
    @(negedge clk);
    key_valid = 1'b1;
    key_value = 4'h3;
    model_key(4'h3);
    @(negedge clk);
    key_valid = 1'b0;
    checks++; if (lcd_req !== 1'b0) begin errors++; $display("FAIL lat_n1_req: got %b, required 0", lcd_req); end
    checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL lat_n1_busy: got %b, required 1", busy); end
    @(negedge clk);
    checks++; if (lcd_req !== 1'b1) begin errors++; $display("FAIL lat_n2_req: got %b, required 1", lcd_req); end
    wait_idle("single");
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 9'h080 || obs_q[1] !== 9'h133) begin
      errors++;
      $display("FAIL single_txns: got %0d txns first %h, required 2 txns 080,133", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 9'h0);
    end
    checks++; if (cur_col !== 4'd1 || cur_row !== 1'd0) begin errors++; $display("FAIL single_cursor: got (%0d,%0d), required (0,1)", cur_row, cur_col); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b, required 0", busy); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_line_wrap();
    do_reset();
    ack_max = 2;
    for (int i = 0; i < 18; i++) begin
      send_key(4'((i < 14) ? i : i - 14), 1'b1);
      wait_idle("wrap_key");
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_txn[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (obs_q.size() > 17 && obs_q[17] !== 9'h0C0) begin errors++; $display("FAIL wrap_row1_addr: got %h, required 0C0", obs_q[17]); end
    checks++; if (cur_row !== 1'd1 || cur_col !== 4'd2) begin errors++; $display("FAIL wrap_cursor: got (%0d,%0d), required (1,2)", cur_row, cur_col); end
  endtask

  task automatic test_grid_wrap();
    do_reset();
    ack_max = 1;
    for (int i = 0; i < 33; i++) begin
      send_key(4'($urandom_range(0, 13)), 1'b1);
      wait_idle("grid_key");
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL grid_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL grid_txn[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (obs_q.size() >= 2 && obs_q[obs_q.size() - 2] !== 9'h080) begin errors++; $display("FAIL grid_home_addr: got %h, required 080", obs_q[obs_q.size() - 2]); end
    checks++; if (cur_row !== 1'd0 || cur_col !== 4'd1) begin errors++; $display("FAIL grid_cursor: got (%0d,%0d), required (0,1)", cur_row, cur_col); end
  endtask

  task automatic test_overflow();
    do_reset();
    ack_max  = 1;
    ack_hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      key_valid = 1'b1;
      key_value = 4'($urandom_range(0, 13));
      if (i < 5) model_key(key_value);
    end
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (drop_cnt != 1)      begin errors++; $display("FAIL ovf_drop: got %0d pulses, required 1", drop_cnt); end
    checks++; if (obs_q.size() != 0)  begin errors++; $display("FAIL ovf_held: got %0d txns, required 0", obs_q.size()); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL ovf_busy: got %b, required 1", busy); end
    ack_hold = 1'b0;
    wait_idle("ovf");
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_txn[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (cur_col !== 4'd5) begin errors++; $display("FAIL ovf_cursor: got col %0d, required 5", cur_col); end
  endtask

  task automatic test_edit();
    do_reset();
    ack_max = 1;
    for (int i = 0; i < 16; i++) begin
      send_key(4'($urandom_range(0, 13)), 1'b1);
      wait_idle("edit_fill");
    end
    obs_q.delete();
    exp_q.delete();
    send_key(4'hE, 1'b1);
    wait_idle("edit_bs");
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 9'h08F || obs_q[1] !== 9'h120) begin
      errors++;
      $display("FAIL bs_txns: got %0d txns first %h, required 08F,120", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 9'h0);
    end
    checks++; if (cur_row !== 1'd0 || cur_col !== 4'd15) begin errors++; $display("FAIL bs_cursor: got (%0d,%0d), required (0,15)", cur_row, cur_col); end
    obs_q.delete();
    exp_q.delete();
    send_key(4'hF, 1'b1);
    wait_idle("edit_clr");
    checks++; if (obs_q.size() != 1 || obs_q[0] !== 9'h001) begin errors++; $display("FAIL clr_txn: got %0d txns, required one 001", obs_q.size()); end
    checks++; if (cur_row !== 1'd0 || cur_col !== 4'd0) begin errors++; $display("FAIL clr_cursor: got (%0d,%0d), required (0,0)", cur_row, cur_col); end
    obs_q.delete();
    exp_q.delete();
    send_key(4'hE, 1'b1);
    wait_idle("edit_bs0");
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL bs_home_quiet: got %0d txns, required 0", obs_q.size()); end
    checks++; if (cur_row !== 1'd0 || cur_col !== 4'd0) begin errors++; $display("FAIL bs_home_cursor: got (%0d,%0d), required (0,0)", cur_row, cur_col); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    ack_max = 0;
    send_key(4'h1, 1'b1);
    send_key(4'h2, 1'b1);
    wait_idle("rmid_pre");
    ack_hold = 1'b1;
    send_key(4'h7, 1'b0);
    send_key(4'h8, 1'b0);
    send_key(4'h9, 1'b0);
    while (!lcd_req && n < 20) begin @(negedge clk); n++; end
    checks++; if (lcd_req !== 1'b1) begin errors++; $display("FAIL rmid_req_up: got %b, required 1", lcd_req); end
    rst = 1'b1;
    #1;
    checks++; if (lcd_req !== 1'b0) begin errors++; $display("FAIL rmid_req_drop: got %b, required 0", lcd_req); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rmid_fifo: busy=%b, required 0", busy); end
    @(negedge clk);
    rst      = 1'b0;
    ack_hold = 1'b0;
    obs_q.delete();
    exp_q.delete();
    m_pos   = 0;
    m_dirty = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (lcd_req !== 1'b0) begin errors++; $display("FAIL rmid_stray: req=%b, required 0", lcd_req); end
    send_key(4'hA, 1'b1);
    wait_idle("rmid_post");
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rmid_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_txn[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (obs_q.size() > 0 && obs_q[0] !== 9'h080) begin errors++; $display("FAIL rmid_addr: got %h, required 080", obs_q[0]); end
  endtask

  task automatic test_random();
    do_reset();
    ack_max = 3;
    for (int b = 0; b < 25; b++) begin
      int len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) begin
        send_key(4'($urandom_range(0, 15)), 1'b1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle("rand_burst");
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_txn[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (int'(cur_row) != m_pos / COLS || int'(cur_col) != m_pos % COLS) begin
      errors++;
      $display("FAIL rand_cursor: got (%0d,%0d), required (%0d,%0d)", cur_row, cur_col, m_pos / COLS, m_pos % COLS);
    end
    checks++; if (drop_cnt != 0) begin errors++; $display("FAIL rand_drop: got %0d pulses, required 0", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_line_wrap();
    test_grid_wrap();
    test_overflow();
    test_edit();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
